// File: rtl/addsub_pkg.sv
// Shared types and helpers for the packed 2x4-bit add/sub issue stage.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int REQ_W = 17;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  typedef struct packed {
    logic       op;
    logic [7:0] in1;
    logic [7:0] in2;
  } req_t;

  function automatic logic signed [3:0] lane_hi(input logic [7:0] v);
    return v[7:4];
  endfunction

  function automatic logic signed [3:0] lane_lo(input logic [7:0] v);
    return v[3:0];
  endfunction

endpackage

// File: rtl/addsub_dispatch_if.sv
// Request, engine and result buses of the add/sub issue stage.
interface addsub_dispatch_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [7:0] req_in1;
  logic [7:0] req_in2;
  logic [7:0] eng_in1;
  logic [7:0] eng_in2;
  logic [1:0] eng_add_or_sub;
  logic [7:0] eng_out;
  logic       eng_done;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic [1:0] res_ovf;

  modport master (
    output req_valid, req_op, req_in1, req_in2, eng_out, eng_done, res_ready,
    input  req_ready, eng_in1, eng_in2, eng_add_or_sub, res_valid, res_data, res_err, res_ovf
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, eng_out, eng_done, res_ready,
    output req_ready, eng_in1, eng_in2, eng_add_or_sub, res_valid, res_data, res_err, res_ovf
  );

endinterface

// File: rtl/addsub_req_fifo.sv
// DEPTH-entry register FIFO holding request words; DEPTH must be a power of 2.
module addsub_req_fifo
  import addsub_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [REQ_W-1:0] i_data,
  input  logic             i_pop,
  output logic [REQ_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [REQ_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/addsub_dispatch.sv
// Issue stage for the packed 2x4-bit signed add/sub engine: queue, issue, capture, timeout.
// Define ADDSUB_OVF_EN to compute per-lane signed-overflow flags on res_ovf.
module addsub_dispatch
  import addsub_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 16,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic               clk,
  input  logic               rst,
  addsub_dispatch_if.slave   bus,
  output logic               busy,
  output logic [CW-1:0]      fifo_count
);

  logic [1:0]       r_state;
  logic [TW-1:0]    r_timer;
  logic [7:0]       r_eng_in1;
  logic [7:0]       r_eng_in2;
  logic             r_op;
  logic             r_res_valid;
  logic [7:0]       r_res_data;
  logic             r_res_err;
  req_t             w_req;
  req_t             w_head;
  logic [REQ_W-1:0] w_fifo_q;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_req         = '{op: bus.req_op, in1: bus.req_in1, in2: bus.req_in2};
  assign w_head        = w_fifo_q;
  assign bus.req_ready = !w_full;
  assign w_push        = bus.req_valid && !w_full;
  assign w_pop         = (r_state == ST_IDLE) && !w_empty;

  addsub_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

`ifdef ADDSUB_OVF_EN
  logic [1:0] r_res_ovf;
  logic [1:0] w_ovf;

  function automatic logic lane_ovf(input logic op, input logic signed [3:0] x,
                                    input logic signed [3:0] y, input logic signed [3:0] r);
    logic same_sign;
    same_sign = (x[3] == y[3]);
    return ((op == OP_ADD) ? same_sign : !same_sign) && (r[3] != x[3]);
  endfunction

  assign w_ovf = {lane_ovf(r_op, lane_hi(r_eng_in1), lane_hi(r_eng_in2), lane_hi(bus.eng_out)),
                  lane_ovf(r_op, lane_lo(r_eng_in1), lane_lo(r_eng_in2), lane_lo(bus.eng_out))};
  assign bus.res_ovf = r_res_ovf;
`else
  assign bus.res_ovf = 2'b00;
`endif

  // Engine operands change only on pop; SETTLE masks a done left over from the previous op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_eng_in1   <= '0;
      r_eng_in2   <= '0;
      r_op        <= OP_ADD;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
`ifdef ADDSUB_OVF_EN
      r_res_ovf   <= 2'b00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_eng_in1 <= w_head.in1;
            r_eng_in2 <= w_head.in2;
            r_op      <= w_head.op;
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.eng_done) begin
            r_res_data  <= bus.eng_out;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
`ifdef ADDSUB_OVF_EN
            r_res_ovf   <= w_ovf;
`endif
            r_state     <= ST_OUT;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_res_data  <= 8'h00;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
`ifdef ADDSUB_OVF_EN
            r_res_ovf   <= 2'b00;
`endif
            r_state     <= ST_OUT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_OUT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.eng_in1        = r_eng_in1;
  assign bus.eng_in2        = r_eng_in2;
  assign bus.eng_add_or_sub = {1'b0, r_op};
  assign bus.res_valid      = r_res_valid;
  assign bus.res_data       = r_res_data;
  assign bus.res_err        = r_res_err;
  assign busy               = (r_state != ST_IDLE);

endmodule

// File: tb/tb_addsub_dispatch.sv
// Directed bench for addsub_dispatch with a behavioural engine (done 2 edges after operands change).
module tb_addsub_dispatch;
  import addsub_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic [CW-1:0] fifo_count;
  int            errors = 0;
  int            checks = 0;
  bit            eng_en = 1'b1;
  logic [16:0]   e_prev;
  logic          e_cnt;

  addsub_dispatch_if bus_if();

  addsub_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] eng_f(input logic [16:0] w);
    logic [3:0] a, b, c, d, h, l;
    a = w[15:12]; b = w[11:8]; c = w[7:4]; d = w[3:0];
    h = w[16] ? (a - c) : (a + c);
    l = w[16] ? (b - d) : (b + d);
    return {h, l};
  endfunction

  // Engine: clears done when operands change, raises it (with result) one edge later, then holds.
  always @(posedge clk) begin
    if (rst) begin
      e_prev          <= '0;
      e_cnt           <= 1'b0;
      bus_if.eng_done <= 1'b0;
      bus_if.eng_out  <= '0;
    end else if ({bus_if.eng_add_or_sub[0], bus_if.eng_in1, bus_if.eng_in2} != e_prev) begin
      e_prev          <= {bus_if.eng_add_or_sub[0], bus_if.eng_in1, bus_if.eng_in2};
      e_cnt           <= 1'b1;
      bus_if.eng_done <= 1'b0;
    end else if (e_cnt && eng_en) begin
      e_cnt           <= 1'b0;
      bus_if.eng_done <= 1'b1;
      bus_if.eng_out  <= eng_f(e_prev);
    end
  end

  task automatic push(input logic op, input logic [7:0] a, input logic [7:0] b);
    bus_if.req_op    = op;
    bus_if.req_in1   = a;
    bus_if.req_in2   = b;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic take();
    bus_if.res_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_if.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus_if.res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus_if.req_ready); end
    checks++; if (bus_if.eng_in1 !== 8'h00 || bus_if.eng_in2 !== 8'h00) begin errors++; $display("FAIL reset_eng_in: got %h/%h want 00/00", bus_if.eng_in1, bus_if.eng_in2); end
    checks++; if (bus_if.eng_add_or_sub !== 2'b00) begin errors++; $display("FAIL reset_eng_op: got %b want 00", bus_if.eng_add_or_sub); end
    checks++; if (bus_if.res_data !== 8'h00 || bus_if.res_err !== 1'b0) begin errors++; $display("FAIL reset_res: got data %h err %b want 00/0", bus_if.res_data, bus_if.res_err); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    bit ok;
    push(OP_ADD, 8'h35, 8'h12);
    @(negedge clk);
    checks++; if (fifo_count !== CW'(1) || bus_if.eng_in1 !== 8'h00) begin errors++; $display("FAIL add_no_bypass: got count %0d eng_in1 %h want 1/00", fifo_count, bus_if.eng_in1); end
    @(negedge clk);
    checks++; if (bus_if.eng_in1 !== 8'h35 || bus_if.eng_in2 !== 8'h12) begin errors++; $display("FAIL add_issue_operands: got %h/%h want 35/12", bus_if.eng_in1, bus_if.eng_in2); end
    checks++; if (bus_if.eng_add_or_sub !== 2'b00) begin errors++; $display("FAIL add_eng_op: got %b want 00", bus_if.eng_add_or_sub); end
    checks++; if (busy !== 1'b1 || fifo_count !== '0) begin errors++; $display("FAIL add_busy_pop: got busy %b count %0d want 1/0", busy, fifo_count); end
    wait_res(ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_res_timeout: got no res_valid want res_valid"); end
    checks++; if (bus_if.res_data !== 8'h47 || bus_if.res_err !== 1'b0) begin errors++; $display("FAIL add_result: got %h err %b want 47/0", bus_if.res_data, bus_if.res_err); end
    checks++; if (bus_if.res_ovf !== 2'b00) begin errors++; $display("FAIL add_ovf: got %b want 00", bus_if.res_ovf); end
    take();
    @(negedge clk);
    checks++; if (bus_if.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_transfer: got valid %b busy %b want 0/0", bus_if.res_valid, busy); end
  endtask

  task automatic test_sub();
    bit ok;
    logic [1:0] exp_ovf;
`ifdef ADDSUB_OVF_EN
    exp_ovf = 2'b10;
`else
    exp_ovf = 2'b00;
`endif
    push(OP_SUB, 8'h35, 8'h12);
    wait_res(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sub_res_timeout: got no res_valid want res_valid"); end
    checks++; if (bus_if.eng_add_or_sub !== 2'b01) begin errors++; $display("FAIL sub_eng_op: got %b want 01", bus_if.eng_add_or_sub); end
    checks++; if (bus_if.res_data !== 8'h23 || bus_if.res_err !== 1'b0) begin errors++; $display("FAIL sub_result: got %h err %b want 23/0", bus_if.res_data, bus_if.res_err); end
    take();
    push(OP_ADD, 8'h70, 8'h10);
    wait_res(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_res_timeout: got no res_valid want res_valid"); end
    checks++; if (bus_if.res_data !== 8'h80) begin errors++; $display("FAIL ovf_result: got %h want 80", bus_if.res_data); end
    checks++; if (bus_if.res_ovf !== exp_ovf) begin errors++; $display("FAIL ovf_flags: got %b want %b", bus_if.res_ovf, exp_ovf); end
    take();
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    eng_en = 1'b0;
    push(OP_SUB, 8'h11, 8'h22);
    push(OP_ADD, 8'h21, 8'h11);
    // Returned just after the pop edge: WAIT starts one edge later, timeout TIMEOUT edges after that.
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus_if.res_valid === 1'b1) break;
    end
    checks++; if (k != TIMEOUT + 2) begin errors++; $display("FAIL timeout_latency: got %0d negedges want %0d", k, TIMEOUT + 2); end
    checks++; if (bus_if.res_data !== 8'h00 || bus_if.res_err !== 1'b1) begin errors++; $display("FAIL timeout_result: got %h err %b want 00/1", bus_if.res_data, bus_if.res_err); end
    checks++; if (bus_if.res_ovf !== 2'b00) begin errors++; $display("FAIL timeout_ovf: got %b want 00", bus_if.res_ovf); end
    checks++; if (bus_if.eng_in1 !== 8'h11 || fifo_count !== CW'(1)) begin errors++; $display("FAIL timeout_hold: got eng_in1 %h count %0d want 11/1", bus_if.eng_in1, fifo_count); end
    eng_en = 1'b1;
    take();
    wait_res(ok);
    checks++; if (!ok) begin errors++; $display("FAIL after_timeout_res: got no res_valid want res_valid"); end
    checks++; if (bus_if.res_data !== 8'h32 || bus_if.res_err !== 1'b0) begin errors++; $display("FAIL after_timeout_result: got %h err %b want 32/0", bus_if.res_data, bus_if.res_err); end
    take();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit extra;
    logic [5:0]  acc;
    logic [16:0] reqs [6];
    logic [7:0]  exp_q [5];
    reqs  = '{{OP_ADD, 8'h11, 8'h11}, {OP_SUB, 8'h54, 8'h21}, {OP_ADD, 8'h12, 8'h34},
              {OP_SUB, 8'h77, 8'h11}, {OP_ADD, 8'h01, 8'h01}, {OP_ADD, 8'h33, 8'h33}};
    exp_q = '{8'h22, 8'h33, 8'h46, 8'h66, 8'h02};
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      {bus_if.req_op, bus_if.req_in1, bus_if.req_in2} = reqs[i];
      bus_if.req_valid = 1'b1;
      @(negedge clk);
      acc[i] = bus_if.req_ready;
      @(posedge clk);
      #1;
    end
    bus_if.req_valid = 1'b0;
    checks++; if (acc !== 6'b011111) begin errors++; $display("FAIL b2b_accept: got %b want 011111", acc); end
    @(negedge clk);
    checks++; if (fifo_count !== CW'(4) || bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got count %0d ready %b want 4/0", fifo_count, bus_if.req_ready); end
    for (int i = 0; i < 5; i++) begin
      wait_res(ok);
      checks++; if (!ok || bus_if.res_data !== exp_q[i]) begin errors++; $display("FAIL b2b_order_%0d: got valid %b data %h want 1/%h", i, ok, bus_if.res_data, exp_q[i]); end
      take();
    end
    extra = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.res_valid === 1'b1) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0 || fifo_count !== '0) begin errors++; $display("FAIL b2b_drained: got extra %b count %0d want 0/0", extra, fifo_count); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    eng_en = 1'b0;
    push(OP_ADD, 8'h13, 8'h24);
    push(OP_ADD, 8'h05, 8'h05);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (bus_if.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got valid %b busy %b want 0/0", bus_if.res_valid, busy); end
    checks++; if (fifo_count !== '0 || bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_fifo: got count %0d ready %b want 0/1", fifo_count, bus_if.req_ready); end
    checks++; if (bus_if.eng_in1 !== 8'h00) begin errors++; $display("FAIL rstmid_eng_in: got %h want 00", bus_if.eng_in1); end
    rst = 1'b0;
    eng_en = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus_if.res_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: got res_valid seen %b busy %b want 0/0", seen, busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stale_done();
    bit ok;
    push(OP_ADD, 8'h22, 8'h11);
    wait_res(ok);
    checks++; if (!ok || bus_if.res_data !== 8'h33) begin errors++; $display("FAIL stale_first: got valid %b data %h want 1/33", ok, bus_if.res_data); end
    take();
    push(OP_SUB, 8'h65, 8'h43);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus_if.eng_done !== 1'b1 || bus_if.eng_in1 !== 8'h65) begin errors++; $display("FAIL stale_setup: got done %b eng_in1 %h want 1/65", bus_if.eng_done, bus_if.eng_in1); end
    @(negedge clk);
    checks++; if (bus_if.res_valid !== 1'b0) begin errors++; $display("FAIL stale_settle: got res_valid %b want 0", bus_if.res_valid); end
    wait_res(ok);
    checks++; if (!ok || bus_if.res_data !== 8'h22 || bus_if.res_err !== 1'b0) begin errors++; $display("FAIL stale_result: got valid %b data %h err %b want 1/22/0", ok, bus_if.res_data, bus_if.res_err); end
    take();
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 1'b0;
    bus_if.req_in1   = 8'h00;
    bus_if.req_in2   = 8'h00;
    bus_if.res_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_stale_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
